// File: rtl/scrambler_pkg.sv
// scrambler_pkg: symbol constants and ordered-set inserter state type shared with the scrambler path
package scrambler_pkg;
  localparam logic [7:0] K28_5_COM = 8'hBC;
  localparam logic [7:0] K28_0_SKP = 8'h1C;
  localparam logic [7:0] IDLE_SYM  = 8'h00;
  typedef enum logic [1:0] {PASS, COM, SKP} skp_state_t;
endpackage

// File: rtl/skp_os_inserter.sv
// skp_os_inserter: feeds scrambler one symbol per clock, forwarding packets, padding with idle, inserting SKP ordered sets between packets
module skp_os_inserter
  import scrambler_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_k,
  input  logic       in_dis_scr,
  input  logic       in_eop,
  output logic [7:0] out_data,
  output logic       out_k,
  output logic       out_dis_scrambler,
  output logic       skp_active
);
  localparam logic [15:0] LAST    = 16'(SKP_INTERVAL - 1);
  localparam logic [15:0] LAST_M1 = 16'(SKP_INTERVAL - 2);
  localparam logic [2:0]  SKP_FIN = 3'(SKP_LEN - 1);
  skp_state_t state;
  logic [15:0] cnt;
  logic [2:0]  skp_cnt;
  logic        skp_due, in_pkt, take;
  assign in_ready = (state == PASS) && !(skp_due && !in_pkt);
  assign take     = in_valid && in_ready;
  // state PASS is already entered while the last SKP is on the output, so a
  // beat accepted then follows the ordered set with no gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= PASS;
      cnt               <= '0;
      skp_cnt           <= '0;
      skp_due           <= 1'b0;
      in_pkt            <= 1'b0;
      out_data          <= IDLE_SYM;
      out_k             <= 1'b0;
      out_dis_scrambler <= 1'b0;
      skp_active        <= 1'b0;
    end else begin
      case (state)
        PASS: begin
          if (skp_due && !in_pkt) begin
            state             <= COM;
            cnt               <= '0;
            skp_due           <= 1'b0;
            out_data          <= K28_5_COM;
            out_k             <= 1'b1;
            out_dis_scrambler <= 1'b0;
            skp_active        <= 1'b1;
          end else begin
            out_data          <= take ? in_data : IDLE_SYM;
            out_k             <= take && in_k;
            out_dis_scrambler <= take && in_dis_scr;
            skp_active        <= 1'b0;
            in_pkt            <= take ? !in_eop : in_pkt;
            cnt               <= (cnt == LAST) ? cnt : cnt + 16'd1;
            skp_due           <= skp_due || (cnt == LAST_M1);
          end
        end
        COM: begin
          state             <= (SKP_LEN == 1) ? PASS : SKP;
          skp_cnt           <= 3'd1;
          out_data          <= K28_0_SKP;
          out_k             <= 1'b1;
          out_dis_scrambler <= 1'b0;
          skp_active        <= 1'b1;
        end
        SKP: begin
          state             <= (skp_cnt == SKP_FIN) ? PASS : SKP;
          skp_cnt           <= skp_cnt + 3'd1;
          out_data          <= K28_0_SKP;
          out_k             <= 1'b1;
          out_dis_scrambler <= 1'b0;
          skp_active        <= 1'b1;
        end
        default: state <= PASS;
      endcase
    end
  end
endmodule

// File: tb/tb_skp_os_inserter.sv
// tb_skp_os_inserter: scoreboard bench for skp_os_inserter with SKP_INTERVAL=8, SKP_LEN=3
module tb_skp_os_inserter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_k = 1'b0;
  logic       in_dis_scr = 1'b0;
  logic       in_eop = 1'b0;
  logic [7:0] out_data;
  logic       out_k, out_dis_scrambler, skp_active;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  typedef struct {
    int         c;
    logic       is_rdy;
    logic [7:0] d;
    logic       k;
    logic       dis;
    logic       s;
    logic       r;
  } exp_t;
  exp_t q[$];
  exp_t e;
  skp_os_inserter #(.SKP_INTERVAL(8), .SKP_LEN(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_k(in_k), .in_dis_scr(in_dis_scr), .in_eop(in_eop),
    .out_data(out_data), .out_k(out_k), .out_dis_scrambler(out_dis_scrambler),
    .skp_active(skp_active)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.is_rdy) begin
        if (e.c != cyc || in_ready !== e.r) begin
          errors++;
          $display("FAIL in_ready cyc %0d: got %b want %b", cyc, in_ready, e.r);
        end
      end else if (e.c != cyc || {out_data, out_k, out_dis_scrambler, skp_active} !== {e.d, e.k, e.dis, e.s}) begin
        errors++;
        $display("FAIL out cyc %0d: got %h k%b d%b s%b want %h k%b d%b s%b",
                 cyc, out_data, out_k, out_dis_scrambler, skp_active, e.d, e.k, e.dis, e.s);
      end
    end
  end
  task automatic step(input logic v, input logic [7:0] d, input logic k, input logic dis,
                      input logic eop, input logic r, input logic [7:0] ed, input logic ek,
                      input logic edis, input logic es);
    in_valid   = v;
    in_data    = d;
    in_k       = k;
    in_dis_scr = dis;
    in_eop     = eop;
    q.push_back('{cyc, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, r});
    q.push_back('{cyc + 1, 1'b0, ed, ek, edis, es, 1'b0});
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input logic r);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, r, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic beat(input logic [7:0] d, input logic eop);
    step(1'b1, d, 1'b0, 1'b0, eop, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic os_seq(input logic v, input logic [7:0] d);
    step(v, d, 1'b0, 1'b0, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b1);
    repeat (3) step(v, d, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b1);
  endtask
  initial begin
    @(posedge clk);
    #1;
    idle(1'b1);
    rst = 1'b0;
    repeat (7) idle(1'b1);
    os_seq(1'b0, 8'h00);
    for (int i = 1; i <= 7; i++) beat(8'(i), 1'b1);
    os_seq(1'b1, 8'h08);
    for (int i = 8; i <= 13; i++) beat(8'(i), 1'b1);
    for (int i = 0; i < 5; i++) beat(8'h20 + 8'(i), i == 4);
    os_seq(1'b0, 8'h00);
    step(1'b1, 8'hBC, 1'b1, 1'b1, 1'b1, 1'b1, 8'hBC, 1'b1, 1'b1, 1'b0);
    repeat (6) idle(1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    repeat (7) idle(1'b1);
    os_seq(1'b0, 8'h00);
    repeat (6) idle(1'b1);
    beat(8'hA1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    beat(8'hA2, 1'b1);
    os_seq(1'b0, 8'h00);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
